regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Arbitrates the single register-file write port between NUM_REQ requesters, for example processor writeback, the multiply/divide unit and the coin-sensor capture path.
- Uses round-robin arbitration with registered outputs.
- Drives the write_enable, address and data of the falling-edge register bank.
- Updates its outputs on the rising edge, so the bank samples them half a cycle later.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register address width.
- DROP_ZERO, 1, when 1 a write to address 0 is acknowledged but never issued.

Ports:
- clk  input  1  system clock, rising-edge active for this block.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request, held until acked.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  output  NUM_REQ  one-hot, one-cycle pulse: the request was accepted.
- write_enable  output  1  write strobe to the register bank.
- write_addr  output  ADDR_WIDTH  bank write address.
- write_data  output  DATA_WIDTH  bank write data.
- grant_idx  output  clog2(NUM_REQ), minimum 1  index of the requester currently being served; valid while ack is nonzero.
- busy  output  1  high if any req bit is high this cycle (combinational OR).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (sampled on a rising edge):
  - ack, write_enable, write_addr, write_data and grant_idx go to 0.
  - Round-robin pointer rr_ptr goes to 0.
- Eligibility:
  - Requester i is eligible in cycle t when req[i]=1 and ack[i]=0 in cycle t.
  - Masking the requester being acked this cycle prevents a double grant while it still holds req.
- Selection: the first eligible index, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
- Registered update on a rising edge with a winner w:
  - ack is one-hot on bit w; grant_idx=w.
  - write_addr and write_data take requester w's fields.
  - write_enable=1, except write_enable=0 when DROP_ZERO=1 and the address is 0.
  - rr_ptr becomes (w+1) mod NUM_REQ.
- Registered update with no winner:
  - ack=0 and write_enable=0.
  - write_addr and write_data hold their previous values.
  - rr_ptr is unchanged.
- Latency: a request sampled at edge k gives ack and write_enable high from edge k to edge k+1. The bank commits on the falling edge within that cycle.
- Throughput:
  - One write per cycle across different requesters.
  - One write per 2 cycles from a single continuously requesting requester, because of ack masking.
- Handshake rules:
  - The requester holds req, addr and data stable until it sees ack.
  - It may drop req, or present a new request, in the cycle it sees ack.
  - Dropping req before ack withdraws the request with no side effects.
- Simultaneous requests: exactly one is granted per cycle. No requester waits more than NUM_REQ-1 grants once eligible.
- Address 0 with DROP_ZERO=1: ack is pulsed, write_enable=0, and rr_ptr still advances.
- Reset while ack or write_enable is high: both clear on that edge. The interrupted requester is considered unserved and must re-request. rr_ptr goes to 0.
- Same-address conflicts: none special. The bank sees writes in grant order, and the last grant wins.
- Requests are never queued internally: the block holds no storage beyond the output registers and rr_ptr.

Test Plan:
- Reset then idle: assert reset for 2 cycles with req=000 → ack=000, write_enable=0, write_addr=0, write_data=0, busy=0.
- Single request:
  - Stimulus: req=001, addr0=5, data0=0x0000_00AB, held until ack.
  - Response: the next edge gives ack=001, write_enable=1, write_addr=5, write_data=0xAB, grant_idx=0.
  - Response: the following cycle gives write_enable=0 once req has been dropped.
- Three-way contention: req=111 held continuously after reset (rr_ptr=0) → grants in order 0,1,2,0,... with one ack per cycle and no index granted twice within any 3 consecutive grants.
- Masking with one requester: req=010 held continuously → ack pattern 010,000,010,000,... and write_enable alternates 1,0.
- Zero drop: req=100, addr2=0, data2=0xFFFF_FFFF → ack=100 and write_enable=0. A following req=001 is granted next with write_enable=1.
- Reset mid-grant: reset asserted in the cycle ack=010 is high → next edge gives ack=000 and write_enable=0. After release with req=011 still held, requester 0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for the register-file write port with registered outputs
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit DROP_ZERO  = 1'b1,
  localparam int IW        = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            write_enable,
  output logic [ADDR_WIDTH-1:0]           write_addr,
  output logic [DATA_WIDTH-1:0]           write_data,
  output logic [IW-1:0]                   grant_idx,
  output logic                            busy
);
  logic [NUM_REQ-1:0]    ack_q, ack_d, elig;
  logic                  we_q, we_d, found;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, w_addr;
  logic [DATA_WIDTH-1:0] data_q, data_d, w_data;
  logic [IW-1:0]         gidx_q, gidx_d, rr_q, rr_d, win;
  logic [IW:0]           sum;
  // the requester acked this cycle is masked so a held req is not granted twice
  assign elig = req & ~ack_q;
  assign busy = |req;
  // descending scan from rr_ptr: the last hit is the nearest eligible index at or after rr_ptr
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (IW+1)'(k);
      sum = sum >= (IW+1)'(NUM_REQ) ? sum - (IW+1)'(NUM_REQ) : sum;
      if (elig[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end
  // pick the winner's address and data out of the packed request buses
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IW'(i)) begin
        w_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  // next-state: pulse ack, strobe the bank unless the write targets a dropped address 0
  always_comb begin
    ack_d  = found ? NUM_REQ'(1) << win : '0;
    we_d   = found && !(DROP_ZERO && w_addr == '0);
    addr_d = found ? w_addr : addr_q;
    data_d = found ? w_data : data_q;
    gidx_d = found ? win : gidx_q;
    rr_d   = found ? (win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1) : rr_q;
  end
  // output and pointer registers; reset abandons any in-flight grant
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      gidx_q <= '0;
      rr_q   <= '0;
    end else begin
      ack_q  <= ack_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      gidx_q <= gidx_d;
      rr_q   <= rr_d;
    end
  end
  assign ack          = ack_q;
  assign write_enable = we_q;
  assign write_addr   = addr_q;
  assign write_data   = data_q;
  assign grant_idx    = gidx_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of the round-robin register-file write arbiter
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [4:0]  a [3];
  logic [31:0] d [3];
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  ack;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [1:0]  grant_idx;
  logic        busy;
  int          total = 0;
  int          bad = 0;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = 3'b000;
    reset = 1'b1;
    tick();
    tick();
    total++; if (ack !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b exp=000", ack); end
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", write_enable); end
    total++; if (write_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", write_addr); end
    total++; if (write_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", write_data); end
    total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL reset_gidx got=%0d exp=0", grant_idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    tick();
    total++; if (ack !== 3'b000 || write_enable !== 1'b0) begin bad++; $display("FAIL idle ack=%b we=%b exp=000/0", ack, write_enable); end
  endtask

  task automatic test_single();
    a[0] = 5'd5; d[0] = 32'h0000_00AB;
    req = 3'b001;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    tick();
    total++; if (ack !== 3'b001) begin bad++; $display("FAIL single_ack got=%b exp=001", ack); end
    total++; if (write_enable !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", write_enable); end
    total++; if (write_addr !== 5'd5) begin bad++; $display("FAIL single_addr got=%0d exp=5", write_addr); end
    total++; if (write_data !== 32'hAB) begin bad++; $display("FAIL single_data got=%h exp=000000ab", write_data); end
    total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL single_gidx got=%0d exp=0", grant_idx); end
    req = 3'b000;
    a[0] = 5'd17; d[0] = 32'h1234_5678;
    tick();
    total++; if (write_enable !== 1'b0 || ack !== 3'b000) begin bad++; $display("FAIL single_after we=%b ack=%b exp=0/000", write_enable, ack); end
    total++; if (write_addr !== 5'd5 || write_data !== 32'hAB) begin bad++; $display("FAIL single_hold addr=%0d data=%h exp=5/000000ab", write_addr, write_data); end
  endtask

  task automatic test_contention();
    logic [2:0] exp_ack [6];
    exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    req = 3'b000;
    do_reset();
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
    d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2;
    req = 3'b111;
    for (int s = 0; s < 6; s++) begin
      tick();
      total++; if (ack !== exp_ack[s]) begin bad++; $display("FAIL rr_ack step=%0d got=%b exp=%b", s, ack, exp_ack[s]); end
      total++; if (grant_idx !== 2'(s % 3) || write_addr !== 5'(s % 3 + 1) || write_data !== 32'(32'hA0 + s % 3))
        begin bad++; $display("FAIL rr_fields step=%0d gidx=%0d addr=%0d data=%h exp_idx=%0d", s, grant_idx, write_addr, write_data, s % 3); end
      total++; if (write_enable !== 1'b1) begin bad++; $display("FAIL rr_we step=%0d got=%b exp=1", s, write_enable); end
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_mask();
    a[1] = 5'd9; d[1] = 32'hBEEF;
    req = 3'b010;
    for (int s = 0; s < 4; s++) begin
      tick();
      total++; if (ack !== (s % 2 == 0 ? 3'b010 : 3'b000)) begin bad++; $display("FAIL mask_ack step=%0d got=%b", s, ack); end
      total++; if (write_enable !== (s % 2 == 0)) begin bad++; $display("FAIL mask_we step=%0d got=%b", s, write_enable); end
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_zero_drop();
    a[2] = 5'd0; d[2] = 32'hFFFF_FFFF;
    req = 3'b100;
    tick();
    total++; if (ack !== 3'b100) begin bad++; $display("FAIL zero_ack got=%b exp=100", ack); end
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL zero_we got=%b exp=0", write_enable); end
    total++; if (write_addr !== 5'd0 || write_data !== 32'hFFFF_FFFF || grant_idx !== 2'd2)
      begin bad++; $display("FAIL zero_fields addr=%0d data=%h gidx=%0d exp=0/ffffffff/2", write_addr, write_data, grant_idx); end
    a[0] = 5'd7; d[0] = 32'h55;
    req = 3'b001;
    tick();
    total++; if (ack !== 3'b001 || write_enable !== 1'b1) begin bad++; $display("FAIL zero_next ack=%b we=%b exp=001/1", ack, write_enable); end
    total++; if (write_addr !== 5'd7 || write_data !== 32'h55) begin bad++; $display("FAIL zero_next_fields addr=%0d data=%h exp=7/55", write_addr, write_data); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    a[0] = 5'd4; a[1] = 5'd9;
    req = 3'b010;
    tick();
    total++; if (ack !== 3'b010) begin bad++; $display("FAIL mid_pre ack=%b exp=010", ack); end
    reset = 1'b1;
    req = 3'b011;
    tick();
    total++; if (ack !== 3'b000 || write_enable !== 1'b0) begin bad++; $display("FAIL mid_reset ack=%b we=%b exp=000/0", ack, write_enable); end
    reset = 1'b0;
    tick();
    total++; if (ack !== 3'b001 || grant_idx !== 2'd0 || write_addr !== 5'd4) begin bad++; $display("FAIL mid_first ack=%b gidx=%0d addr=%0d exp=001/0/4", ack, grant_idx, write_addr); end
    req = 3'b010;
    tick();
    total++; if (ack !== 3'b010 || grant_idx !== 2'd1 || write_addr !== 5'd9) begin bad++; $display("FAIL mid_second ack=%b gidx=%0d addr=%0d exp=010/1/9", ack, grant_idx, write_addr); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_withdraw();
    a[2] = 5'd12; d[2] = 32'hCAFE;
    req = 3'b100;
    #1;
    req = 3'b000;
    tick();
    total++; if (ack !== 3'b000 || write_enable !== 1'b0) begin bad++; $display("FAIL withdraw ack=%b we=%b exp=000/0", ack, write_enable); end
  endtask

  initial begin
    reset = 1'b0;
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    test_reset();
    test_single();
    test_contention();
    test_mask();
    test_zero_drop();
    test_reset_mid();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
